// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Initiator side of the byte-cell data memory interface. Takes one word-wide
// load or store from the datapath over a valid/ready handshake. It then issues
// two byte accesses to the memory in big-endian order: the high byte at addr
// and the low byte at addr+1. The +1 wraps modulo 2^ADDR_LEN. For every
// accepted request it returns a one-cycle completion strobe. The strobe carries
// an error flag when the memory stops acknowledging for ACK_TIMEOUT cycles in a
// single byte phase.
//
// Optional build macro:
//   MISALIGN_TRAP_EN  When defined, a request at an odd address is accepted
//                     but never reaches the memory. It completes on the next
//                     cycle with resp_err=1.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   req_valid   in   datapath request present
//   req_ready   out  unit can accept a request (IDLE only)
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address of the word
//   req_wdata   in   store data
//   resp_valid  out  one-cycle completion strobe
//   resp_rdata  out  load result (updated only by a successful load)
//   resp_err    out  qualifies resp_valid: access aborted
//   mem_req     out  byte access active
//   mem_we      out  byte write
//   mem_addr    out  byte address
//   mem_wdata   out  byte to write
//   mem_rdata   in   byte read
//   mem_ack     in   memory completes the current byte access this cycle
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_LEN    = 16,
    parameter int WORD_LEN    = 16,
    parameter int CELL_LEN    = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [WORD_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [WORD_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [CELL_LEN-1:0] mem_wdata,
    input  logic [CELL_LEN-1:0] mem_rdata,
    input  logic                mem_ack
);

    // The wait counter only needs to reach ACK_TIMEOUT-1. A phase whose counter
    // is at that value and still sees no ack has waited ACK_TIMEOUT cycles.
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                r_we;
    logic [ADDR_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [CELL_LEN-1:0] r_hi;      // high byte of a load in progress
    logic [WORD_LEN-1:0] r_rdata;   // last successfully loaded word
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_last_wait;
    logic                w_misalign;
    logic [ADDR_LEN-1:0] w_addr_lo;

    assign w_last_wait = (r_cnt == CNT_LAST);
    assign w_addr_lo   = r_addr + ADDR_LEN'(1);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = req_addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. The outputs come from r_state and the
    // latched request only, so req_* never reaches mem_* in one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        resp_rdata   = r_rdata;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = w_misalign ? S_DONE : S_HI;
                end
            end
            S_HI: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_wdata[WORD_LEN-1:CELL_LEN];
                if (mem_ack) begin
                    w_state_next = S_LO;
                end else if (w_last_wait) begin
                    w_state_next = S_DONE;
                end
            end
            S_LO: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_addr_lo;
                mem_wdata = r_wdata[CELL_LEN-1:0];
                if (mem_ack || w_last_wait) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid   = 1'b1;
                resp_err     = r_err;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, read assembly, error flag and ack wait counter.
    // r_err is set when a request is accepted (misaligned trap) or when a
    // phase times out. Its value matters only in DONE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_err   <= w_misalign;
                    end
                end
                S_HI: begin
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_hi <= mem_rdata;
                        end
                        r_cnt <= '0;
                    end else if (w_last_wait) begin
                        r_err <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LO: begin
                    if (mem_ack) begin
                        // Commit the whole word only when both bytes arrived,
                        // so an aborted load leaves resp_rdata untouched.
                        if (!r_we) begin
                            r_rdata <= {r_hi, mem_rdata};
                        end
                        r_cnt <= '0;
                    end else if (w_last_wait) begin
                        r_err <= 1'b1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed testbench for mem_access_unit. A byte-array memory model answers
// the DUT's byte accesses. The model can delay each ack and can stop acking
// after a set number of accesses. Each scenario task drives its stimulus and
// compares the DUT outputs against hand-computed values, one cycle at a time.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_rdata;

    // Memory model controls
    logic [7:0]  mem [0:65535];
    int          ack_delay  = 0;
    int          ack_budget = 1000000;
    int          wait_cnt   = 0;

    mem_access_unit #(
        .ADDR_LEN   (16),
        .WORD_LEN   (16),
        .CELL_LEN   (8),
        .ACK_TIMEOUT(15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model. It decides the ack for each cycle on the falling edge,
    // when the DUT outputs are stable. A write lands when it is acked.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && ack_budget > 0 && wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
                ack_budget = ack_budget - 1;
                wait_cnt   = 0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'h00;
                wait_cnt  = (mem_req === 1'b1) ? wait_cnt + 1 : 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle and step through the accept edge.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input bit hold);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL issue_ready: req_ready=%b expected 1", req_ready); end
        tick();
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        tick(); tick();
        checks++; if (req_ready  !== 1'b1)  begin errors++; $display("FAIL rst_req_ready: %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0)  begin errors++; $display("FAIL rst_resp_valid: %b expected 0", resp_valid); end
        checks++; if (resp_err   !== 1'b0)  begin errors++; $display("FAIL rst_resp_err: %b expected 0", resp_err); end
        checks++; if (resp_rdata !== 16'h0) begin errors++; $display("FAIL rst_resp_rdata: %h expected 0000", resp_rdata); end
        checks++; if (mem_req    !== 1'b0)  begin errors++; $display("FAIL rst_mem_req: %b expected 0", mem_req); end
        checks++; if (mem_we     !== 1'b0)  begin errors++; $display("FAIL rst_mem_we: %b expected 0", mem_we); end
        checks++; if (mem_addr   !== 16'h0) begin errors++; $display("FAIL rst_mem_addr: %h expected 0000", mem_addr); end
        checks++; if (mem_wdata  !== 8'h0)  begin errors++; $display("FAIL rst_mem_wdata: %h expected 00", mem_wdata); end
        rst = 1'b0;
        exp_rdata = 16'h0000;
        tick();
        $display("reset: outputs idle");
    endtask

    task automatic test_store_immediate();
        ack_delay = 0; ack_budget = 1000000;
        issue(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        // cycle 1: high byte
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL st_c1_req: req=%b we=%b expected 1 1", mem_req, mem_we); end
        checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL st_c1_addr: %h expected 0010", mem_addr); end
        checks++; if (mem_wdata !== 8'hBE) begin errors++; $display("FAIL st_c1_wdata: %h expected BE", mem_wdata); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL st_c1_ready: %b expected 0", req_ready); end
        tick();
        // cycle 2: low byte
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL st_c2_req: req=%b we=%b expected 1 1", mem_req, mem_we); end
        checks++; if (mem_addr !== 16'h0011) begin errors++; $display("FAIL st_c2_addr: %h expected 0011", mem_addr); end
        checks++; if (mem_wdata !== 8'hEF) begin errors++; $display("FAIL st_c2_wdata: %h expected EF", mem_wdata); end
        tick();
        // cycle 3: response
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL st_c3_resp: valid=%b err=%b expected 1 0", resp_valid, resp_err); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL st_c3_mem_req: %b expected 0", mem_req); end
        checks++; if (resp_rdata !== exp_rdata) begin errors++; $display("FAIL st_c3_rdata: %h expected %h", resp_rdata, exp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL st_c4_idle: valid=%b ready=%b expected 0 1", resp_valid, req_ready); end
        checks++; if (mem[16'h0010] !== 8'hBE || mem[16'h0011] !== 8'hEF) begin errors++; $display("FAIL st_mem: %h%h expected BEEF", mem[16'h0010], mem[16'h0011]); end
        $display("store addr=0010 data=BEEF immediate ack");
    endtask

    task automatic test_load_delayed();
        ack_delay = 3; ack_budget = 1000000;
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);
        for (int c = 1; c <= 8; c++) begin
            checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL ld_wait_c%0d: valid=%b ready=%b expected 0 0", c, resp_valid, req_ready); end
            checks++; if (mem_addr !== ((c <= 4) ? 16'h0010 : 16'h0011)) begin errors++; $display("FAIL ld_addr_c%0d: %h expected %h", c, mem_addr, (c <= 4) ? 16'h0010 : 16'h0011); end
            tick();
        end
        exp_rdata = 16'hBEEF;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL ld_c9_resp: valid=%b err=%b expected 1 0", resp_valid, resp_err); end
        checks++; if (resp_rdata !== 16'hBEEF) begin errors++; $display("FAIL ld_c9_rdata: %h expected BEEF", resp_rdata); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL ld_c10_valid: %b expected 0", resp_valid); end
        $display("load addr=0010 delay=3 rdata=%h", resp_rdata);
        ack_delay = 0;
    endtask

`ifndef MISALIGN_TRAP_EN
    task automatic test_wrap_load();
        ack_delay = 0; ack_budget = 1000000;
        mem[16'hFFFF] = 8'h12;
        mem[16'h0000] = 8'h34;
        issue(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        checks++; if (mem_addr !== 16'hFFFF || mem_we !== 1'b0) begin errors++; $display("FAIL wrap_c1: addr=%h we=%b expected FFFF 0", mem_addr, mem_we); end
        tick();
        checks++; if (mem_addr !== 16'h0000 || mem_req !== 1'b1) begin errors++; $display("FAIL wrap_c2: addr=%h req=%b expected 0000 1", mem_addr, mem_req); end
        tick();
        exp_rdata = 16'h1234;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h1234 || resp_err !== 1'b0) begin errors++; $display("FAIL wrap_c3: valid=%b rdata=%h err=%b expected 1 1234 0", resp_valid, resp_rdata, resp_err); end
        tick();
        $display("load addr=FFFF wrap rdata=%h", resp_rdata);
    endtask
`endif

    task automatic test_timeout_hi();
        ack_delay = 0; ack_budget = 0;
        issue(1'b0, 16'h0020, 16'h0000, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0020 || resp_valid !== 1'b0) begin errors++; $display("FAIL tohi_c%0d: req=%b addr=%h valid=%b expected 1 0020 0", c, mem_req, mem_addr, resp_valid); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL tohi_c16_resp: valid=%b err=%b expected 1 1", resp_valid, resp_err); end
        checks++; if (resp_rdata !== exp_rdata) begin errors++; $display("FAIL tohi_c16_rdata: %h expected %h", resp_rdata, exp_rdata); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL tohi_c16_mem_req: %b expected 0", mem_req); end
        tick();
        // Next request accepted straight away; the model now acks normally.
        ack_budget = 1000000;
        issue(1'b0, 16'h0010, 16'h0000, 1'b0);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0010) begin errors++; $display("FAIL tohi_next: req=%b addr=%h expected 1 0010", mem_req, mem_addr); end
        tick(); tick();
        exp_rdata = 16'hBEEF;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'hBEEF) begin errors++; $display("FAIL tohi_next_resp: valid=%b err=%b rdata=%h expected 1 0 BEEF", resp_valid, resp_err, resp_rdata); end
        tick();
        $display("load addr=0020 timeout in high phase, err=1");
    endtask

    task automatic test_timeout_lo_store();
        ack_delay = 0; ack_budget = 1;
        issue(1'b1, 16'h0030, 16'h7788, 1'b0);
        tick();
        for (int c = 2; c <= 16; c++) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0031 || resp_valid !== 1'b0) begin errors++; $display("FAIL tolo_c%0d: req=%b addr=%h valid=%b expected 1 0031 0", c, mem_req, mem_addr, resp_valid); end
            tick();
        end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== exp_rdata) begin errors++; $display("FAIL tolo_c17: valid=%b err=%b rdata=%h expected 1 1 %h", resp_valid, resp_err, resp_rdata, exp_rdata); end
        checks++; if (mem[16'h0030] !== 8'h77 || mem[16'h0031] !== 8'h00) begin errors++; $display("FAIL tolo_mem: %h%h expected 7700", mem[16'h0030], mem[16'h0031]); end
        tick();
        ack_budget = 1000000;
        $display("store addr=0030 data=7788 timeout in low phase, err=1");
    endtask

    task automatic test_rst_mid();
        mem[16'h0040] = 8'h5A;
        mem[16'h0041] = 8'hA5;
        ack_delay = 0; ack_budget = 1;
        issue(1'b0, 16'h0040, 16'h0000, 1'b1);
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0041) begin errors++; $display("FAIL rstmid_lo: req=%b addr=%h expected 1 0041", mem_req, mem_addr); end
        rst = 1'b1;
        tick();
        exp_rdata = 16'h0000;
        checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: req=%b valid=%b ready=%b expected 0 0 1", mem_req, resp_valid, req_ready); end
        checks++; if (resp_rdata !== 16'h0000) begin errors++; $display("FAIL rstmid_rdata: %h expected 0000", resp_rdata); end
        rst = 1'b0;
        ack_budget = 1000000;
        tick();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_reaccept: req=%b addr=%h valid=%b expected 1 0040 0", mem_req, mem_addr, resp_valid); end
        tick(); tick();
        exp_rdata = 16'h5AA5;
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 16'h5AA5) begin errors++; $display("FAIL rstmid_resp: valid=%b err=%b rdata=%h expected 1 0 5AA5", resp_valid, resp_err, resp_rdata); end
        tick();
        $display("load addr=0040 interrupted by reset, reissued rdata=%h", resp_rdata);
    endtask

    task automatic test_back_to_back();
        ack_delay = 0; ack_budget = 1000000;
        issue(1'b1, 16'h0100, 16'h1122, 1'b1);
        // Request B held on the bus while A is in flight.
        req_addr = 16'h0200; req_wdata = 16'h3344;
        checks++; if (mem_addr !== 16'h0100 || mem_wdata !== 8'h11) begin errors++; $display("FAIL b2b_c1: addr=%h wdata=%h expected 0100 11", mem_addr, mem_wdata); end
        tick(); tick();
        checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL b2b_c3: valid=%b ready=%b expected 1 0", resp_valid, req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_c4: ready=%b req=%b expected 1 0", req_ready, mem_req); end
        tick();
        req_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0200 || mem_wdata !== 8'h33) begin errors++; $display("FAIL b2b_c5: req=%b addr=%h wdata=%h expected 1 0200 33", mem_req, mem_addr, mem_wdata); end
        tick(); tick();
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp_rdata) begin errors++; $display("FAIL b2b_c7: valid=%b err=%b rdata=%h expected 1 0 %h", resp_valid, resp_err, resp_rdata, exp_rdata); end
        checks++; if (mem[16'h0200] !== 8'h33 || mem[16'h0201] !== 8'h44 || mem[16'h0101] !== 8'h22) begin errors++; $display("FAIL b2b_mem: %h%h %h expected 3344 22", mem[16'h0200], mem[16'h0201], mem[16'h0101]); end
        tick();
        $display("back-to-back stores 0100=1122 0200=3344");
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        ack_delay = 0; ack_budget = 1000000;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_c0_req: %b expected 0", mem_req); end
        issue(1'b0, 16'h0003, 16'h0000, 1'b0);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mis_c1_req: %b expected 0", mem_req); end
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== exp_rdata) begin errors++; $display("FAIL mis_c1_resp: valid=%b err=%b rdata=%h expected 1 1 %h", resp_valid, resp_err, resp_rdata, exp_rdata); end
        tick();
        checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mis_c2: req=%b valid=%b ready=%b expected 0 0 1", mem_req, resp_valid, req_ready); end
        $display("load addr=0003 misaligned trap");
    endtask
`endif

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        exp_rdata = 16'h0000;
        test_reset();
        test_store_immediate();
        test_load_delayed();
`ifndef MISALIGN_TRAP_EN
        test_wrap_load();
`endif
        test_timeout_hi();
        test_timeout_lo_store();
        test_rst_mid();
        test_back_to_back();
`ifdef MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
